// File: rtl/cdu_pkg.sv
// rtl/cdu_pkg.sv - shared constants and FSM state type for the CDU error-pulse link
//
// Contents:
//   CDU_CNT_W       default width of command, remaining and angle registers
//   CLOCKH_HZ       CLOCKH frequency in Hz
//   PULSE_RATE_PPS  AFxPCH pulse rate; CLOCKH_HZ / PULSE_RATE_PPS gives the slot length
//   state_t         drain FSM states

package cdu_pkg;

  localparam int CDU_CNT_W      = 15;
  localparam int CLOCKH_HZ      = 51200;
  localparam int PULSE_RATE_PPS = 3200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/cdu_angle_counter.sv
// rtl/cdu_angle_counter.sv - CDU angle up/down counter fed by ATpPGH/ATmPGH rising edges
//
// Ports:
//   clk        in   1      CLOCKH
//   rst_n      in   1      asynchronous active-low reset
//   inc_pulse  in   1      +1 angle pulse (ATpPGH)
//   dec_pulse  in   1      -1 angle pulse (ATmPGH)
//   angle      out  CNT_W  two's complement angle, wraps mod 2^CNT_W

module cdu_angle_counter
  import cdu_pkg::*;
#(
  parameter int CNT_W = CDU_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_pulse,
  input  logic             dec_pulse,
  output logic [CNT_W-1:0] angle
);

  logic inc_q;
  logic dec_q;
  logic inc_rise;
  logic dec_rise;

  // A pulse held for several cycles counts once, on its first cycle.
  assign inc_rise = inc_pulse & ~inc_q;
  assign dec_rise = dec_pulse & ~dec_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      angle <= '0;
    end else begin
      inc_q <= inc_pulse;
      dec_q <= dec_pulse;
      // Simultaneous + and - edges cancel.
      if (inc_rise && !dec_rise) begin
        angle <= angle + 1'b1;
      end else if (dec_rise && !inc_rise) begin
        angle <= angle - 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdu_err_pulse_tx.sv
// rtl/cdu_err_pulse_tx.sv - AGC-side CDU error-counter pulse drain and angle counter
//
// Ports:
//   CLOCKH     in   1      51.2 kHz clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   err_en     in   1      pulse drain permitted
//   cmd_valid  in   1      command offered
//   cmd_ready  out  1      command accepted on cmd_valid & cmd_ready
//   cmd_count  in   CNT_W  signed pulse count (>0 AFpPCH, <0 AFmPCH)
//   abort      in   1      discard remaining count at next slot boundary
//   AFpPCH     out  1      positive error-counter pulse
//   AFmPCH     out  1      negative error-counter pulse
//   busy       out  1      command in progress
//   done       out  1      one-cycle strobe: command finished or aborted
//   remaining  out  CNT_W  unsigned pulses still to send
//   ATpPGH     in   1      CDU +1 angle pulse
//   ATmPGH     in   1      CDU -1 angle pulse
//   angle      out  CNT_W  accumulated CDU angle

module cdu_err_pulse_tx
  import cdu_pkg::*;
#(
  parameter int CNT_W    = CDU_CNT_W,
  parameter int RATE_DIV = CLOCKH_HZ / PULSE_RATE_PPS,
  parameter int PULSE_W  = 1
) (
  input  logic             CLOCKH,
  input  logic             rst_n,
  input  logic             err_en,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic             AFpPCH,
  output logic             AFmPCH,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  input  logic             ATpPGH,
  input  logic             ATmPGH,
  output logic [CNT_W-1:0] angle
);

  localparam int                SLOT_W     = $clog2(RATE_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(RATE_DIV - 1);
  localparam logic [SLOT_W-1:0] PULSE_LAST = SLOT_W'(PULSE_W - 1);

  state_t            state;
  logic [SLOT_W-1:0] slot_cnt;    // cycle index within the current pulse slot
  logic              dir_neg;     // 1 = drain on AFmPCH
  logic              abort_seen;  // abort observed earlier in the current slot
  logic [CNT_W-1:0]  cmd_mag;

  // Magnitude of the most negative count is 2^(CNT_W-1), which still fits unsigned.
  assign cmd_mag   = cmd_count[CNT_W-1] ? (~cmd_count + CNT_W'(1)) : cmd_count;
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      slot_cnt   <= '0;
      dir_neg    <= 1'b0;
      abort_seen <= 1'b0;
      remaining  <= '0;
      AFpPCH     <= 1'b0;
      AFmPCH     <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_neg    <= cmd_count[CNT_W-1];
            remaining  <= cmd_mag;
            abort_seen <= 1'b0;
            slot_cnt   <= '0;
            if (cmd_mag == '0) begin
              done <= 1'b1;
            end else if (err_en) begin
              AFpPCH <= ~cmd_count[CNT_W-1];
              AFmPCH <= cmd_count[CNT_W-1];
              state  <= PULSE;
            end else begin
              state <= HOLD;
            end
          end
        end

        PULSE: begin
          if (abort) abort_seen <= 1'b1;
          // The count is consumed on the first cycle of the pulse.
          if (slot_cnt == '0) remaining <= remaining - 1'b1;
          slot_cnt <= slot_cnt + 1'b1;
          if (slot_cnt == PULSE_LAST) begin
            AFpPCH <= 1'b0;
            AFmPCH <= 1'b0;
            state  <= GAP;
          end
        end

        GAP: begin
          if (slot_cnt != SLOT_LAST) begin
            if (abort) abort_seen <= 1'b1;
            slot_cnt <= slot_cnt + 1'b1;
          end else if (remaining == '0 || abort_seen || abort) begin
            remaining <= '0;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (!err_en) begin
            state <= HOLD;
          end else begin
            slot_cnt   <= '0;
            abort_seen <= 1'b0;
            AFpPCH     <= ~dir_neg;
            AFmPCH     <= dir_neg;
            state      <= PULSE;
          end
        end

        HOLD: begin
          if (abort) begin
            remaining <= '0;
            done      <= 1'b1;
            state     <= IDLE;
          end else if (err_en) begin
            slot_cnt   <= '0;
            abort_seen <= 1'b0;
            AFpPCH     <= ~dir_neg;
            AFmPCH     <= dir_neg;
            state      <= PULSE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  cdu_angle_counter #(
    .CNT_W(CNT_W)
  ) u_angle (
    .clk       (CLOCKH),
    .rst_n     (rst_n),
    .inc_pulse (ATpPGH),
    .dec_pulse (ATmPGH),
    .angle     (angle)
  );

endmodule

// File: tb/tb_cdu_err_pulse_tx.sv
// tb/tb_cdu_err_pulse_tx.sv - directed self-checking bench for cdu_err_pulse_tx

module tb_cdu_err_pulse_tx;

  logic        CLOCKH = 1'b0;
  logic        rst_n;
  logic        err_en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [14:0] cmd_count;
  logic        abort;
  logic        AFpPCH;
  logic        AFmPCH;
  logic        busy;
  logic        done;
  logic [14:0] remaining;
  logic        ATpPGH;
  logic        ATmPGH;
  logic [14:0] angle;

  int n_assert = 0;
  int n_fail   = 0;

  // Pulse monitor (only this block writes these)
  int   ncyc = 0, p_starts = 0, m_starts = 0, p_hi = 0, m_hi = 0;
  int   overlap = 0, done_cnt = 0, bad_spacing = 0, last_start = -1;
  logic p_prev = 1'b0, m_prev = 1'b0;

  cdu_err_pulse_tx dut (
    .CLOCKH    (CLOCKH),
    .rst_n     (rst_n),
    .err_en    (err_en),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .abort     (abort),
    .AFpPCH    (AFpPCH),
    .AFmPCH    (AFmPCH),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .ATpPGH    (ATpPGH),
    .ATmPGH    (ATmPGH),
    .angle     (angle)
  );

  always #5 CLOCKH = ~CLOCKH;

  always @(negedge CLOCKH) begin : mon
    logic ns;
    ns = 1'b0;
    ncyc = ncyc + 1;
    if (AFpPCH) p_hi = p_hi + 1;
    if (AFmPCH) m_hi = m_hi + 1;
    if (AFpPCH && AFmPCH) overlap = overlap + 1;
    if (AFpPCH && !p_prev) begin p_starts = p_starts + 1; ns = 1'b1; end
    if (AFmPCH && !m_prev) begin m_starts = m_starts + 1; ns = 1'b1; end
    if (ns) begin
      if (last_start >= 0 && (ncyc - last_start) != 16) bad_spacing = bad_spacing + 1;
      last_start = ncyc;
    end
    if (!busy) last_start = -1;
    if (done) done_cnt = done_cnt + 1;
    p_prev = AFpPCH;
    m_prev = AFmPCH;
  end

  task automatic step();
    @(negedge CLOCKH);
    #1;
  endtask

  // Offer one command; returns in the first cycle after the accepting edge.
  task automatic issue(input logic [14:0] cnt);
    cmd_valid = 1'b1;
    cmd_count = cnt;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; err_en = 1'b0; cmd_valid = 1'b0; cmd_count = '0;
    abort = 1'b0; ATpPGH = 1'b0; ATmPGH = 1'b0;
    #3;
    n_assert++; if ({AFpPCH, AFmPCH, busy, done} !== 4'b0000) begin n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {AFpPCH, AFmPCH, busy, done}); end
    n_assert++; if (remaining !== 15'd0) begin n_fail++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
    n_assert++; if (angle !== 15'd0) begin n_fail++; $display("FAIL reset_angle: got %0d expected 0", angle); end
    n_assert++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_drain_pos();
    int k, s_p, s_m, s_ph, s_sp, s_d;
    err_en = 1'b1;
    s_p = p_starts; s_m = m_starts; s_ph = p_hi; s_sp = bad_spacing; s_d = done_cnt;
    issue(15'd384);
    k = 1;
    n_assert++; if (AFpPCH !== 1'b1) begin n_fail++; $display("FAIL t1_first_pulse_latency: got %b expected 1", AFpPCH); end
    n_assert++; if (remaining !== 15'd384) begin n_fail++; $display("FAIL t1_remaining_start: got %0d expected 384", remaining); end
    n_assert++; if ({busy, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL t1_busy_ready: got %b expected 10", {busy, cmd_ready}); end
    while (!done && k < 7000) begin step(); k++; end
    n_assert++; if (k !== 6145) begin n_fail++; $display("FAIL t1_done_cycle: got %0d expected 6145", k); end
    n_assert++; if (p_starts - s_p !== 384) begin n_fail++; $display("FAIL t1_p_pulses: got %0d expected 384", p_starts - s_p); end
    n_assert++; if (p_hi - s_ph !== 384) begin n_fail++; $display("FAIL t1_p_high_cycles: got %0d expected 384", p_hi - s_ph); end
    n_assert++; if (m_starts - s_m !== 0) begin n_fail++; $display("FAIL t1_no_m_pulses: got %0d expected 0", m_starts - s_m); end
    n_assert++; if (bad_spacing - s_sp !== 0) begin n_fail++; $display("FAIL t1_spacing: got %0d bad gaps expected 0", bad_spacing - s_sp); end
    n_assert++; if (remaining !== 15'd0) begin n_fail++; $display("FAIL t1_remaining_end: got %0d expected 0", remaining); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_end: got %b expected 0", busy); end
    step();
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL t1_done_strobe_width: got %b expected 0", done); end
    n_assert++; if (done_cnt - s_d !== 1) begin n_fail++; $display("FAIL t1_done_count: got %0d expected 1", done_cnt - s_d); end
  endtask

  task automatic test_drain_neg();
    int s_p, s_m, s_d, s_sp;
    err_en = 1'b1;
    s_p = p_starts; s_m = m_starts; s_d = done_cnt; s_sp = bad_spacing;
    issue(-15'sd5);
    for (int i = 0; i < 5; i++) begin
      n_assert++; if (AFmPCH !== 1'b1) begin n_fail++; $display("FAIL t2_m_pulse_%0d: got %b expected 1", i, AFmPCH); end
      n_assert++; if (remaining !== 15'(5 - i)) begin n_fail++; $display("FAIL t2_remaining_%0d: got %0d expected %0d", i, remaining, 5 - i); end
      if (i == 1) begin cmd_valid = 1'b1; cmd_count = 15'd100; end
      if (i == 2) begin
        n_assert++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL t2_ready_while_busy: got %b expected 0", cmd_ready); end
      end
      if (i == 3) cmd_valid = 1'b0;
      repeat (16) step();
    end
    n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL t2_done_cycle: got %b expected 1", done); end
    n_assert++; if (remaining !== 15'd0) begin n_fail++; $display("FAIL t2_remaining_end: got %0d expected 0", remaining); end
    n_assert++; if (m_starts - s_m !== 5) begin n_fail++; $display("FAIL t2_m_pulses: got %0d expected 5", m_starts - s_m); end
    n_assert++; if (p_starts - s_p !== 0) begin n_fail++; $display("FAIL t2_no_p_pulses: got %0d expected 0", p_starts - s_p); end
    n_assert++; if (done_cnt - s_d !== 1) begin n_fail++; $display("FAIL t2_done_count: got %0d expected 1", done_cnt - s_d); end
    n_assert++; if (bad_spacing - s_sp !== 0) begin n_fail++; $display("FAIL t2_spacing: got %0d bad gaps expected 0", bad_spacing - s_sp); end
    step();
  endtask

  task automatic test_err_en_hold();
    int k, s_p;
    err_en = 1'b1;
    s_p = p_starts;
    issue(15'd10);
    k = 1;
    repeat (48) begin step(); k++; end
    n_assert++; if (AFpPCH !== 1'b1) begin n_fail++; $display("FAIL t3_pulse4_start: got %b expected 1", AFpPCH); end
    n_assert++; if (remaining !== 15'd7) begin n_fail++; $display("FAIL t3_remaining_pulse4: got %0d expected 7", remaining); end
    err_en = 1'b0;
    repeat (21) begin step(); k++; end
    n_assert++; if ({busy, AFpPCH} !== 2'b10) begin n_fail++; $display("FAIL t3_hold_state: got %b expected 10", {busy, AFpPCH}); end
    n_assert++; if (remaining !== 15'd6) begin n_fail++; $display("FAIL t3_hold_remaining: got %0d expected 6", remaining); end
    n_assert++; if (p_starts - s_p !== 4) begin n_fail++; $display("FAIL t3_pulses_before_hold: got %0d expected 4", p_starts - s_p); end
    err_en = 1'b1;
    step(); k++;
    n_assert++; if (AFpPCH !== 1'b1) begin n_fail++; $display("FAIL t3_resume_latency: got %b expected 1", AFpPCH); end
    while (!done && k < 400) begin step(); k++; end
    n_assert++; if (k !== 167) begin n_fail++; $display("FAIL t3_done_cycle: got %0d expected 167", k); end
    n_assert++; if (p_starts - s_p !== 10) begin n_fail++; $display("FAIL t3_total_pulses: got %0d expected 10", p_starts - s_p); end
    step();
  endtask

  task automatic test_abort();
    int k, s_p, s_d;
    err_en = 1'b1;
    s_p = p_starts; s_d = done_cnt;
    issue(15'd100);
    k = 1;
    repeat (32) begin step(); k++; end
    n_assert++; if (AFpPCH !== 1'b1) begin n_fail++; $display("FAIL t4_pulse3_start: got %b expected 1", AFpPCH); end
    abort = 1'b1;
    step(); k++;
    abort = 1'b0;
    repeat (6) begin step(); k++; end
    n_assert++; if (remaining !== 15'd97) begin n_fail++; $display("FAIL t4_remaining_mid_slot: got %0d expected 97", remaining); end
    while (!done && k < 200) begin step(); k++; end
    n_assert++; if (k !== 49) begin n_fail++; $display("FAIL t4_done_cycle: got %0d expected 49", k); end
    n_assert++; if (remaining !== 15'd0) begin n_fail++; $display("FAIL t4_remaining_cleared: got %0d expected 0", remaining); end
    step();
    n_assert++; if (p_starts - s_p !== 3) begin n_fail++; $display("FAIL t4_pulses: got %0d expected 3", p_starts - s_p); end
    n_assert++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL t4_ready_after_abort: got %b expected 1", cmd_ready); end
    issue(15'd2);
    k = 1;
    n_assert++; if (remaining !== 15'd2) begin n_fail++; $display("FAIL t4_new_cmd_remaining: got %0d expected 2", remaining); end
    while (!done && k < 200) begin step(); k++; end
    n_assert++; if (k !== 33) begin n_fail++; $display("FAIL t4_new_cmd_done_cycle: got %0d expected 33", k); end
    n_assert++; if (p_starts - s_p !== 5) begin n_fail++; $display("FAIL t4_total_pulses: got %0d expected 5", p_starts - s_p); end
    n_assert++; if (done_cnt - s_d !== 2) begin n_fail++; $display("FAIL t4_done_count: got %0d expected 2", done_cnt - s_d); end
    step();
  endtask

  task automatic test_zero_and_min();
    int k, s_m, s_p;
    err_en = 1'b1;
    s_m = m_starts; s_p = p_starts;
    issue(15'd0);
    n_assert++; if ({done, busy, cmd_ready} !== 3'b101) begin n_fail++; $display("FAIL t5_zero_done: got %b expected 101", {done, busy, cmd_ready}); end
    n_assert++; if ({AFpPCH, AFmPCH} !== 2'b00) begin n_fail++; $display("FAIL t5_zero_no_pulse: got %b expected 00", {AFpPCH, AFmPCH}); end
    issue(15'h4000);
    k = 1;
    n_assert++; if (remaining !== 15'd16384) begin n_fail++; $display("FAIL t5_min_magnitude: got %0d expected 16384", remaining); end
    n_assert++; if ({AFpPCH, AFmPCH} !== 2'b01) begin n_fail++; $display("FAIL t5_min_direction: got %b expected 01", {AFpPCH, AFmPCH}); end
    repeat (16) begin step(); k++; end
    n_assert++; if (remaining !== 15'd16383) begin n_fail++; $display("FAIL t5_min_second_pulse: got %0d expected 16383", remaining); end
    abort = 1'b1;
    step(); k++;
    abort = 1'b0;
    while (!done && k < 200) begin step(); k++; end
    n_assert++; if (k !== 33) begin n_fail++; $display("FAIL t5_abort_done_cycle: got %0d expected 33", k); end
    n_assert++; if (m_starts - s_m !== 2) begin n_fail++; $display("FAIL t5_m_pulses: got %0d expected 2", m_starts - s_m); end
    n_assert++; if (p_starts - s_p !== 0) begin n_fail++; $display("FAIL t5_no_p_pulses: got %0d expected 0", p_starts - s_p); end
    step();
  endtask

  task automatic test_angle();
    err_en = 1'b0;
    ATpPGH = 1'b1; repeat (3) step(); ATpPGH = 1'b0; step();
    n_assert++; if (angle !== 15'd1) begin n_fail++; $display("FAIL t6_wide_pulse_once: got %0d expected 1", angle); end
    repeat (2) begin ATpPGH = 1'b1; step(); ATpPGH = 1'b0; step(); end
    ATmPGH = 1'b1; step(); ATmPGH = 1'b0; step();
    ATpPGH = 1'b1; ATmPGH = 1'b1; step(); ATpPGH = 1'b0; ATmPGH = 1'b0; step();
    n_assert++; if (angle !== 15'd2) begin n_fail++; $display("FAIL t6_angle_mix: got %0d expected 2", angle); end
    repeat (16381) begin ATpPGH = 1'b1; step(); ATpPGH = 1'b0; step(); end
    n_assert++; if (angle !== 15'h3FFF) begin n_fail++; $display("FAIL t6_angle_max: got %h expected 3fff", angle); end
    ATpPGH = 1'b1; step(); ATpPGH = 1'b0; step();
    n_assert++; if (angle !== 15'h4000) begin n_fail++; $display("FAIL t6_angle_wrap: got %h expected 4000", angle); end
    ATmPGH = 1'b1; step(); ATmPGH = 1'b0; step();
    n_assert++; if (angle !== 15'h3FFF) begin n_fail++; $display("FAIL t6_angle_unwrap: got %h expected 3fff", angle); end
  endtask

  task automatic test_async_reset();
    err_en = 1'b1;
    issue(15'd50);
    n_assert++; if (AFpPCH !== 1'b1) begin n_fail++; $display("FAIL t7_pre_reset_pulse: got %b expected 1", AFpPCH); end
    rst_n = 1'b0;
    #1;
    n_assert++; if ({AFpPCH, AFmPCH, busy, done} !== 4'b0000) begin n_fail++; $display("FAIL t7_async_outputs: got %b expected 0000", {AFpPCH, AFmPCH, busy, done}); end
    n_assert++; if (remaining !== 15'd0) begin n_fail++; $display("FAIL t7_async_remaining: got %0d expected 0", remaining); end
    n_assert++; if (angle !== 15'd0) begin n_fail++; $display("FAIL t7_async_angle: got %h expected 0", angle); end
    n_assert++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL t7_async_ready: got %b expected 1", cmd_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_drain_pos();
    test_drain_neg();
    test_err_en_hold();
    test_abort();
    test_zero_and_min();
    test_angle();
    test_async_reset();
    n_assert++; if (overlap !== 0) begin n_fail++; $display("FAIL never_both_high: got %0d overlap cycles expected 0", overlap); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
